// File: rtl/mmu_pkg.sv
// MMU shared types: TLB<->PTW request/response payloads and the PTW arbiter state encoding.
package mmu_pkg;

   localparam int unsigned PTW_ARB_N_REQ = 2;
   localparam int unsigned VPN_W         = 27;
   localparam int unsigned ASID_W        = 9;
   localparam int unsigned PTE_W         = 64;
   localparam int unsigned LEVEL_W       = 2;

   typedef struct packed {
      logic              valid;
      logic [ASID_W-1:0] asid;
      logic [VPN_W-1:0]  vpn;
   } tlb_ptw_req_t;

   typedef struct packed {
      tlb_ptw_req_t req;
   } tlb_ptw_comm_t;

   typedef struct packed {
      logic               valid;
      logic               error;
      logic [LEVEL_W-1:0] level;
      logic [PTE_W-1:0]   pte;
   } ptw_tlb_resp_t;

   typedef struct packed {
      logic [1:0] prv;
      logic       sum;
      logic       mxr;
   } ptw_status_t;

   typedef struct packed {
      ptw_tlb_resp_t resp;
      logic          ptw_ready;
      logic          invalidate_tlb;
      ptw_status_t   ptw_status;
   } ptw_tlb_comm_t;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      GRANT      = 2'd1,
      WAIT       = 2'd2,
      FLUSH_WAIT = 2'd3
   } ptw_arb_state_t;

endpackage

// File: rtl/ptw_arb_if.sv
// TLB-side and PTW-side buses of the PTW arbiter; slave = arbiter, master = TLBs/PTW environment.
interface ptw_arb_if #(
   parameter int unsigned N_REQ = mmu_pkg::PTW_ARB_N_REQ
) ();
   import mmu_pkg::*;

   tlb_ptw_comm_t tlb_ptw_comm_i [N_REQ];
   ptw_tlb_comm_t ptw_tlb_comm_o [N_REQ];
   tlb_ptw_comm_t tlb_ptw_comm_o;
   ptw_tlb_comm_t ptw_tlb_comm_i;

   modport slave (
      input  tlb_ptw_comm_i,
      input  ptw_tlb_comm_i,
      output ptw_tlb_comm_o,
      output tlb_ptw_comm_o
   );

   modport master (
      output tlb_ptw_comm_i,
      output ptw_tlb_comm_i,
      input  ptw_tlb_comm_o,
      input  tlb_ptw_comm_o
   );
endinterface

// File: rtl/ptw_arb_sel.sv
// PTW arbiter winner selection: round-robin from rr_ptr, or highest-index-wins
// fixed priority when PTW_ARB_FIXED_PRIO_EN is defined (rr_ptr port then absent).
module ptw_arb_sel
   import mmu_pkg::*;
#(
   parameter  int unsigned N_REQ = PTW_ARB_N_REQ,
   localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] valid,
`ifndef PTW_ARB_FIXED_PRIO_EN
   input  logic [IDX_W-1:0] rr_ptr,
`endif
   output logic [IDX_W-1:0] winner,
   output logic             any_valid
);

   assign any_valid = |valid;

`ifdef PTW_ARB_FIXED_PRIO_EN
   // Later (higher) indices overwrite earlier ones, so the highest valid wins.
   always_comb begin
      winner = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         if (valid[k]) winner = IDX_W'(k);
      end
   end
`else
   logic [N_REQ-1:0] rot;
   logic             found;
   int unsigned      pos;

   // Rotate so bit 0 is rr_ptr, take the first set bit, map back with wrap.
   always_comb begin
      rot    = N_REQ'({valid, valid} >> rr_ptr);
      winner = '0;
      found  = 1'b0;
      pos    = 0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         if (!found && rot[k]) begin
            found = 1'b1;
            pos   = 32'(rr_ptr) + k;
            if (pos >= N_REQ) pos = pos - N_REQ;
            winner = IDX_W'(pos);
         end
      end
   end
`endif

endmodule

// File: rtl/ptw_arb.sv
// Arbitrates N_REQ TLBs onto one page-table walker and routes the walk result back.
// Define PTW_ARB_FIXED_PRIO_EN for fixed priority (highest index wins) instead of round-robin.
module ptw_arb
   import mmu_pkg::*;
#(
   parameter int unsigned N_REQ = PTW_ARB_N_REQ
) (
   input  logic     clk_i,
   input  logic     rstn_i,
   ptw_arb_if.slave bus,
   output logic     arb_busy_o
);

   localparam int unsigned      IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

   ptw_arb_state_t   state_q;
   logic [IDX_W-1:0] grant_q;
   logic [N_REQ-1:0] req_valid;
   logic [IDX_W-1:0] winner;
   logic             any_valid;
   tlb_ptw_comm_t    gnt_req;
   logic             ptw_ready;
   logic             resp_valid;
   logic             inval;
`ifndef PTW_ARB_FIXED_PRIO_EN
   logic [IDX_W-1:0] rr_ptr_q;
`endif

   assign ptw_ready  = bus.ptw_tlb_comm_i.ptw_ready;
   assign resp_valid = bus.ptw_tlb_comm_i.resp.valid;
   assign inval      = bus.ptw_tlb_comm_i.invalidate_tlb;

   // Valid vector for selection and the request of the current grantee.
   always_comb begin
      req_valid = '0;
      gnt_req   = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         req_valid[i] = bus.tlb_ptw_comm_i[i].req.valid;
         if (IDX_W'(i) == grant_q) gnt_req = bus.tlb_ptw_comm_i[i];
      end
   end

   ptw_arb_sel #(
      .N_REQ     (N_REQ)
   ) u_sel (
      .valid     (req_valid),
`ifndef PTW_ARB_FIXED_PRIO_EN
      .rr_ptr    (rr_ptr_q),
`endif
      .winner    (winner),
      .any_valid (any_valid)
   );

   // Arbitration FSM; busy flag is registered alongside the state it mirrors.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         arb_busy_o <= 1'b0;
`ifndef PTW_ARB_FIXED_PRIO_EN
         rr_ptr_q   <= '0;
`endif
      end else begin
         unique case (state_q)
            IDLE: begin
               if (any_valid) begin
                  grant_q    <= winner;
                  state_q    <= GRANT;
                  arb_busy_o <= 1'b1;
               end
            end
            GRANT: begin
               if (!gnt_req.req.valid) begin
                  state_q    <= IDLE;
                  arb_busy_o <= 1'b0;
               end else if (ptw_ready) begin
                  state_q <= inval ? FLUSH_WAIT : WAIT;
               end
            end
            WAIT, FLUSH_WAIT: begin
               // A response always completes, even alongside an invalidate.
               if (resp_valid) begin
                  state_q    <= IDLE;
                  arb_busy_o <= 1'b0;
`ifndef PTW_ARB_FIXED_PRIO_EN
                  rr_ptr_q   <= (grant_q == LAST_IDX) ? '0 : grant_q + IDX_W'(1);
`endif
               end else if (inval) begin
                  state_q <= FLUSH_WAIT;
               end
            end
            default: begin
               state_q    <= IDLE;
               arb_busy_o <= 1'b0;
            end
         endcase
      end
   end

   // Payload broadcast to everyone; ready and resp.valid only to the grantee.
   always_comb begin
      bus.tlb_ptw_comm_o = (state_q == GRANT) ? gnt_req : '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         bus.ptw_tlb_comm_o[i]            = bus.ptw_tlb_comm_i;
         bus.ptw_tlb_comm_o[i].ptw_ready  = (state_q == GRANT) && (IDX_W'(i) == grant_q)
                                            && ptw_ready;
         bus.ptw_tlb_comm_o[i].resp.valid = ((state_q == WAIT) || (state_q == FLUSH_WAIT))
                                            && (IDX_W'(i) == grant_q) && resp_valid;
      end
   end

endmodule

// File: tb/tb_ptw_arb.sv
// Testbench for ptw_arb: directed scenarios plus randomized traffic against a transaction-level model.
module tb_ptw_arb;
   import mmu_pkg::*;

   localparam int unsigned N = PTW_ARB_N_REQ;

   logic clk_i;
   logic rstn_i;
   logic arb_busy_o;
   int   checks;
   int   errors;

   ptw_arb_if #(.N_REQ(N)) bus ();

   ptw_arb #(.N_REQ(N)) dut (
      .clk_i      (clk_i),
      .rstn_i     (rstn_i),
      .bus        (bus),
      .arb_busy_o (arb_busy_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not end, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic clear_inputs();
      for (int i = 0; i < N; i++) bus.tlb_ptw_comm_i[i] = '0;
      bus.ptw_tlb_comm_i = '0;
   endtask

   task automatic set_req(input int i, input logic v, input logic [VPN_W-1:0] vpn);
      bus.tlb_ptw_comm_i[i].req.valid = v;
      bus.tlb_ptw_comm_i[i].req.vpn   = vpn;
      bus.tlb_ptw_comm_i[i].req.asid  = ASID_W'(i + 3);
   endtask

   // Leaves the bench at a falling edge with reset just released and inputs idle.
   task automatic do_reset();
      @(negedge clk_i);
      rstn_i = 1'b0;
      clear_inputs();
      repeat (2) @(negedge clk_i);
      rstn_i = 1'b1;
   endtask

   // Reference winner, straight from the arbitration rule.
   function automatic int pick(input logic [N-1:0] v, input int ptr);
      int r;
      r = -1;
`ifdef PTW_ARB_FIXED_PRIO_EN
      for (int k = 0; k < N; k++) if (v[k]) r = k;
      if (ptr < 0) r = -1;
`else
      for (int k = N - 1; k >= 0; k--) if (v[(ptr + k) % N]) r = (ptr + k) % N;
`endif
      return r;
   endfunction

   task automatic test_reset();
      rstn_i = 1'b0;
      clear_inputs();
      set_req(0, 1'b1, 27'h00abc);
      bus.ptw_tlb_comm_i.ptw_ready      = 1'b1;
      bus.ptw_tlb_comm_i.resp.valid     = 1'b1;
      bus.ptw_tlb_comm_i.resp.pte       = 64'hdead_beef_0123_4567;
      bus.ptw_tlb_comm_i.invalidate_tlb = 1'b1;
      repeat (3) @(negedge clk_i);
      #1;
      checks++;
      if (arb_busy_o !== 1'b0) begin
         errors++; $display("FAIL reset_busy got=%0b exp=0", arb_busy_o);
      end
      checks++;
      if (bus.tlb_ptw_comm_o !== tlb_ptw_comm_t'('0)) begin
         errors++; $display("FAIL reset_ptw_req got=%0h exp=0", bus.tlb_ptw_comm_o);
      end
      for (int i = 0; i < N; i++) begin
         checks++;
         if (bus.ptw_tlb_comm_o[i].ptw_ready !== 1'b0 || bus.ptw_tlb_comm_o[i].resp.valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_route[%0d] got ready=%0b rvalid=%0b exp 0/0", i,
                     bus.ptw_tlb_comm_o[i].ptw_ready, bus.ptw_tlb_comm_o[i].resp.valid);
         end
         checks++;
         if (bus.ptw_tlb_comm_o[i].resp.pte !== 64'hdead_beef_0123_4567
             || bus.ptw_tlb_comm_o[i].invalidate_tlb !== 1'b1) begin
            errors++;
            $display("FAIL reset_bcast[%0d] got pte=%0h inv=%0b exp pte=deadbeef01234567 inv=1", i,
                     bus.ptw_tlb_comm_o[i].resp.pte, bus.ptw_tlb_comm_o[i].invalidate_tlb);
         end
      end
      clear_inputs();
      @(negedge clk_i);
      rstn_i = 1'b1;
   endtask

   task automatic test_single();
      do_reset();
      set_req(0, 1'b1, 27'h12345);
      #1;
      checks++;
      if (bus.tlb_ptw_comm_o.req.valid !== 1'b0) begin
         errors++; $display("FAIL single_cycle0 got=%0b exp=0", bus.tlb_ptw_comm_o.req.valid);
      end
      @(negedge clk_i); #1;
      checks++;
      if (bus.tlb_ptw_comm_o.req.valid !== 1'b1 || bus.tlb_ptw_comm_o.req.vpn !== 27'h12345) begin
         errors++;
         $display("FAIL single_forward got v=%0b vpn=%0h exp v=1 vpn=12345",
                  bus.tlb_ptw_comm_o.req.valid, bus.tlb_ptw_comm_o.req.vpn);
      end
      @(negedge clk_i);
      bus.ptw_tlb_comm_i.ptw_ready = 1'b1;
      #1;
      checks++;
      if (bus.ptw_tlb_comm_o[0].ptw_ready !== 1'b1 || bus.ptw_tlb_comm_o[1].ptw_ready !== 1'b0) begin
         errors++;
         $display("FAIL single_ready got itlb=%0b dtlb=%0b exp 1/0",
                  bus.ptw_tlb_comm_o[0].ptw_ready, bus.ptw_tlb_comm_o[1].ptw_ready);
      end
      @(negedge clk_i);
      bus.ptw_tlb_comm_i.ptw_ready  = 1'b0;
      set_req(0, 1'b0, 27'h0);
      bus.ptw_tlb_comm_i.resp.valid = 1'b1;
      bus.ptw_tlb_comm_i.resp.pte   = 64'h0000_0000_0123_4c01;
      #1;
      checks++;
      if (bus.ptw_tlb_comm_o[0].resp.valid !== 1'b1 || bus.ptw_tlb_comm_o[1].resp.valid !== 1'b0) begin
         errors++;
         $display("FAIL single_resp got itlb=%0b dtlb=%0b exp 1/0",
                  bus.ptw_tlb_comm_o[0].resp.valid, bus.ptw_tlb_comm_o[1].resp.valid);
      end
      @(negedge clk_i);
      bus.ptw_tlb_comm_i.resp.valid = 1'b0;
      #1;
      checks++;
      if (arb_busy_o !== 1'b0) begin
         errors++; $display("FAIL single_idle got=%0b exp=0", arb_busy_o);
      end
   endtask

   task automatic test_contention();
      logic [VPN_W-1:0] vpns [N];
      int               exp;
      vpns[0] = 27'h0aaaa;
      vpns[1] = 27'h05555;
      do_reset();
      set_req(0, 1'b1, vpns[0]);
      set_req(1, 1'b1, vpns[1]);
      for (int r = 0; r < 3; r++) begin
`ifdef PTW_ARB_FIXED_PRIO_EN
         exp = 1;
`else
         exp = r % 2;
`endif
         #1;
         checks++;
         if (arb_busy_o !== 1'b0) begin
            errors++; $display("FAIL cont_idle[%0d] got=%0b exp=0", r, arb_busy_o);
         end
         @(negedge clk_i); #1;
         checks++;
         if (bus.tlb_ptw_comm_o.req.vpn !== vpns[exp]) begin
            errors++;
            $display("FAIL cont_grant[%0d] got vpn=%0h exp vpn=%0h", r, bus.tlb_ptw_comm_o.req.vpn, vpns[exp]);
         end
         bus.ptw_tlb_comm_i.ptw_ready = 1'b1;
         #1;
         checks++;
         if (bus.ptw_tlb_comm_o[exp].ptw_ready !== 1'b1 || bus.ptw_tlb_comm_o[1-exp].ptw_ready !== 1'b0) begin
            errors++;
            $display("FAIL cont_ready[%0d] got win=%0b lose=%0b exp 1/0", r,
                     bus.ptw_tlb_comm_o[exp].ptw_ready, bus.ptw_tlb_comm_o[1-exp].ptw_ready);
         end
         @(negedge clk_i);
         bus.ptw_tlb_comm_i.ptw_ready  = 1'b0;
         bus.ptw_tlb_comm_i.resp.valid = 1'b1;
         #1;
         checks++;
         if (bus.ptw_tlb_comm_o[exp].resp.valid !== 1'b1 || bus.ptw_tlb_comm_o[1-exp].resp.valid !== 1'b0) begin
            errors++;
            $display("FAIL cont_resp[%0d] got win=%0b lose=%0b exp 1/0", r,
                     bus.ptw_tlb_comm_o[exp].resp.valid, bus.ptw_tlb_comm_o[1-exp].resp.valid);
         end
         @(negedge clk_i);
         bus.ptw_tlb_comm_i.resp.valid = 1'b0;
      end
   endtask

   task automatic test_cancel();
      do_reset();
      set_req(1, 1'b1, 27'h7beef);
      @(negedge clk_i); #1;
      checks++;
      if (bus.tlb_ptw_comm_o.req.valid !== 1'b1 || bus.tlb_ptw_comm_o.req.vpn !== 27'h7beef) begin
         errors++;
         $display("FAIL cancel_grant got v=%0b vpn=%0h exp v=1 vpn=7beef",
                  bus.tlb_ptw_comm_o.req.valid, bus.tlb_ptw_comm_o.req.vpn);
      end
      set_req(1, 1'b0, 27'h7beef);
      @(negedge clk_i);
      bus.ptw_tlb_comm_i.ptw_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         checks++;
         if (arb_busy_o !== 1'b0 || bus.tlb_ptw_comm_o !== tlb_ptw_comm_t'('0)
             || bus.ptw_tlb_comm_o[1].ptw_ready !== 1'b0) begin
            errors++;
            $display("FAIL cancel_idle[%0d] got busy=%0b req=%0h rdy=%0b exp 0/0/0", k,
                     arb_busy_o, bus.tlb_ptw_comm_o, bus.ptw_tlb_comm_o[1].ptw_ready);
         end
         @(negedge clk_i);
      end
      bus.ptw_tlb_comm_i.ptw_ready = 1'b0;
   endtask

   task automatic test_invalidate();
      do_reset();
      set_req(0, 1'b1, 27'h00042);
      @(negedge clk_i);
      bus.ptw_tlb_comm_i.ptw_ready = 1'b1;
      @(negedge clk_i);
      bus.ptw_tlb_comm_i.ptw_ready      = 1'b0;
      set_req(0, 1'b0, 27'h0);
      bus.ptw_tlb_comm_i.invalidate_tlb = 1'b1;
      #1;
      checks++;
      if (bus.ptw_tlb_comm_o[0].invalidate_tlb !== 1'b1 || bus.ptw_tlb_comm_o[1].invalidate_tlb !== 1'b1) begin
         errors++;
         $display("FAIL inv_bcast got itlb=%0b dtlb=%0b exp 1/1",
                  bus.ptw_tlb_comm_o[0].invalidate_tlb, bus.ptw_tlb_comm_o[1].invalidate_tlb);
      end
      for (int k = 1; k < 5; k++) begin
         @(negedge clk_i);
         bus.ptw_tlb_comm_i.invalidate_tlb = 1'b0;
         #1;
         checks++;
         if (arb_busy_o !== 1'b1) begin
            errors++; $display("FAIL inv_hold[%0d] got busy=%0b exp=1", k, arb_busy_o);
         end
      end
      @(negedge clk_i);
      bus.ptw_tlb_comm_i.resp.valid = 1'b1;
      bus.ptw_tlb_comm_i.resp.pte   = 64'h0000_0000_0000_0c0f;
      bus.ptw_tlb_comm_i.resp.level = 2'd1;
      #1;
      checks++;
      if (bus.ptw_tlb_comm_o[0].resp.valid !== 1'b1 || bus.ptw_tlb_comm_o[1].resp.valid !== 1'b0
          || bus.ptw_tlb_comm_o[0].resp.pte !== 64'h0c0f) begin
         errors++;
         $display("FAIL inv_resp got itlb=%0b dtlb=%0b pte=%0h exp 1/0 pte=c0f",
                  bus.ptw_tlb_comm_o[0].resp.valid, bus.ptw_tlb_comm_o[1].resp.valid,
                  bus.ptw_tlb_comm_o[0].resp.pte);
      end
      @(negedge clk_i);
      bus.ptw_tlb_comm_i.resp.valid = 1'b0;
      #1;
      checks++;
      if (arb_busy_o !== 1'b0) begin
         errors++; $display("FAIL inv_idle got busy=%0b exp=0", arb_busy_o);
      end
   endtask

   task automatic test_isolation();
      do_reset();
      set_req(0, 1'b1, 27'h01111);
      @(negedge clk_i);
      bus.ptw_tlb_comm_i.ptw_ready = 1'b1;
      @(negedge clk_i);
      set_req(0, 1'b0, 27'h0);
      set_req(1, 1'b1, 27'h02222);
      for (int k = 0; k < 20; k++) begin
         bus.ptw_tlb_comm_i.ptw_ready  = 1'($urandom_range(0, 1));
         bus.ptw_tlb_comm_i.resp.valid = (k == 19);
         #1;
         checks++;
         if (bus.ptw_tlb_comm_o[1].ptw_ready !== 1'b0 || bus.ptw_tlb_comm_o[1].resp.valid !== 1'b0
             || bus.tlb_ptw_comm_o.req.valid !== 1'b0) begin
            errors++;
            $display("FAIL iso_dtlb[%0d] got rdy=%0b rvalid=%0b fwd=%0b exp 0/0/0", k,
                     bus.ptw_tlb_comm_o[1].ptw_ready, bus.ptw_tlb_comm_o[1].resp.valid,
                     bus.tlb_ptw_comm_o.req.valid);
         end
         @(negedge clk_i);
      end
      bus.ptw_tlb_comm_i.ptw_ready  = 1'b0;
      bus.ptw_tlb_comm_i.resp.valid = 1'b0;
      @(negedge clk_i); #1;
      checks++;
      if (bus.tlb_ptw_comm_o.req.vpn !== 27'h02222 || arb_busy_o !== 1'b1) begin
         errors++;
         $display("FAIL iso_grant got vpn=%0h busy=%0b exp vpn=2222 busy=1",
                  bus.tlb_ptw_comm_o.req.vpn, arb_busy_o);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      set_req(0, 1'b1, 27'h03333);
      @(negedge clk_i);
      bus.ptw_tlb_comm_i.ptw_ready = 1'b1;
      @(negedge clk_i);
      bus.ptw_tlb_comm_i.ptw_ready = 1'b0;
      set_req(0, 1'b0, 27'h0);
      rstn_i = 1'b0;
      #1;
      checks++;
      if (arb_busy_o !== 1'b0) begin
         errors++; $display("FAIL rstmid_busy got=%0b exp=0", arb_busy_o);
      end
      @(negedge clk_i);
      rstn_i = 1'b1;
      bus.ptw_tlb_comm_i.resp.valid = 1'b1;
      #1;
      checks++;
      if (bus.ptw_tlb_comm_o[0].resp.valid !== 1'b0 || bus.ptw_tlb_comm_o[1].resp.valid !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_stale got itlb=%0b dtlb=%0b exp 0/0",
                  bus.ptw_tlb_comm_o[0].resp.valid, bus.ptw_tlb_comm_o[1].resp.valid);
      end
      @(negedge clk_i);
      bus.ptw_tlb_comm_i.resp.valid = 1'b0;
   endtask

   // Model: owner = requester holding the walker (-1 none), hs = PTW accepted its request.
   task automatic test_random();
      int            owner;
      bit            hs;
      int            ptr;
      logic [N-1:0]  vv;
      tlb_ptw_comm_t exp_fw;
      ptw_tlb_comm_t exp_o;
      do_reset();
      owner = -1;
      hs    = 1'b0;
      ptr   = 0;
      for (int c = 0; c < 3000; c++) begin
         rstn_i = 1'b1;
         for (int i = 0; i < N; i++) begin
            if (bus.tlb_ptw_comm_i[i].req.valid) begin
               if ($urandom_range(0, 15) == 0) bus.tlb_ptw_comm_i[i].req.valid = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
               set_req(i, 1'b1, VPN_W'($urandom));
            end
         end
         bus.ptw_tlb_comm_i.ptw_ready      = ($urandom_range(0, 2) == 0);
         bus.ptw_tlb_comm_i.resp.valid     = ($urandom_range(0, 3) == 0);
         bus.ptw_tlb_comm_i.resp.error     = 1'($urandom);
         bus.ptw_tlb_comm_i.resp.level     = LEVEL_W'($urandom);
         bus.ptw_tlb_comm_i.resp.pte       = {$urandom, $urandom};
         bus.ptw_tlb_comm_i.invalidate_tlb = ($urandom_range(0, 9) == 0);
         bus.ptw_tlb_comm_i.ptw_status     = 4'($urandom);
         if ($urandom_range(0, 199) == 0) begin
            rstn_i = 1'b0;
            owner  = -1;
            hs     = 1'b0;
            ptr    = 0;
         end
         #1;
         checks++;
         if (arb_busy_o !== (owner >= 0)) begin
            errors++; $display("FAIL rand_busy[%0d] got=%0b exp=%0b", c, arb_busy_o, owner >= 0);
         end
         exp_fw = '0;
         if (owner >= 0 && !hs) exp_fw = bus.tlb_ptw_comm_i[owner];
         checks++;
         if (bus.tlb_ptw_comm_o !== exp_fw) begin
            errors++; $display("FAIL rand_fwd[%0d] got=%0h exp=%0h", c, bus.tlb_ptw_comm_o, exp_fw);
         end
         for (int i = 0; i < N; i++) begin
            exp_o            = bus.ptw_tlb_comm_i;
            exp_o.ptw_ready  = (owner == i) && !hs && bus.ptw_tlb_comm_i.ptw_ready;
            exp_o.resp.valid = (owner == i) && hs && bus.ptw_tlb_comm_i.resp.valid;
            checks++;
            if (bus.ptw_tlb_comm_o[i] !== exp_o) begin
               errors++;
               $display("FAIL rand_rsp[%0d][%0d] got=%0h exp=%0h", c, i, bus.ptw_tlb_comm_o[i], exp_o);
            end
         end
         @(posedge clk_i);
         if (rstn_i) begin
            for (int i = 0; i < N; i++) vv[i] = bus.tlb_ptw_comm_i[i].req.valid;
            if (owner < 0) begin
               owner = pick(vv, ptr);
               hs    = 1'b0;
            end else if (!hs) begin
               if (!vv[owner]) owner = -1;
               else if (bus.ptw_tlb_comm_i.ptw_ready) hs = 1'b1;
            end else if (bus.ptw_tlb_comm_i.resp.valid) begin
               ptr   = (owner + 1) % N;
               owner = -1;
            end
         end
         @(negedge clk_i);
      end
      rstn_i = 1'b1;
      clear_inputs();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rstn_i = 1'b0;
      clear_inputs();
      test_reset();
      test_single();
      test_contention();
      test_cancel();
      test_invalidate();
      test_isolation();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ptw_arb.md
PTW_ARB -- requirements
Module: ptw_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 2, number of TLB requesters sharing one PTW (index 0 = ITLB, 1 = DTLB).
REQ-002 SHALL have port clk_i, input, 1, single clock; all state updates on the rising edge.
REQ-003 SHALL have port rstn_i, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port tlb_ptw_comm_i, input, tlb_ptw_comm_t [N_REQ], per-requester PTW request.
REQ-005 SHALL have port ptw_tlb_comm_o, output, ptw_tlb_comm_t [N_REQ], per-requester PTW response, ready and status.
REQ-006 SHALL have port tlb_ptw_comm_o, output, tlb_ptw_comm_t, request forwarded to the PTW.
REQ-007 SHALL have port ptw_tlb_comm_i, input, ptw_tlb_comm_t, PTW response, ready, invalidate and status.
REQ-008 SHALL have port arb_busy_o, output, 1, high whenever the state is not IDLE.

Function
REQ-009 SHALL implement FSM states IDLE, GRANT, WAIT and FLUSH_WAIT.
REQ-010 In IDLE, when any req.valid is high, SHALL register the winner index into grant_q and move to GRANT; the PTW sees the request 1 cycle after it is first presented.
REQ-011 Winner selection SHALL be round-robin: search upward from rr_ptr_q with wrap-around at N_REQ-1, taking the first valid index.
REQ-012 In GRANT, SHALL drive tlb_ptw_comm_o.req from requester grant_q and drive tlb_ptw_comm_o.req to all-zero in every other state.
REQ-013 In GRANT, ptw_ready SHALL reach only requester grant_q; all other requesters SHALL see ptw_ready = 0.
REQ-014 In GRANT, when the granted req.valid = 0 (requester cancelled), SHALL return to IDLE without a PTW handshake.
REQ-015 In GRANT, when ptw_ready = 1 and req.valid = 1, SHALL go to WAIT, or to FLUSH_WAIT if invalidate_tlb = 1 in the same cycle.
REQ-016 In WAIT, resp.valid SHALL be routed only to requester grant_q; on resp.valid SHALL go to IDLE and set rr_ptr_q = (grant_q+1) mod N_REQ.
REQ-017 In WAIT, when invalidate_tlb = 1 and resp.valid = 0, SHALL go to FLUSH_WAIT.
REQ-018 In FLUSH_WAIT, the response SHALL still be routed to requester grant_q; on resp.valid SHALL go to IDLE and advance rr_ptr_q as in REQ-016.
REQ-019 SHALL broadcast resp payload (pte, level, error), invalidate_tlb and ptw_status to all requesters combinationally every cycle, independent of state.
REQ-020 Requests arriving while not in IDLE SHALL be ignored until IDLE; no request is queued internally.
REQ-021 Simultaneous resp.valid and invalidate_tlb in WAIT SHALL be treated as completion: go to IDLE.

Reset
REQ-022 Reset SHALL set state = IDLE, grant_q = 0, rr_ptr_q = 0, arb_busy_o = 0, all-zero PTW request, and all per-requester resp.valid and ptw_ready = 0.
REQ-023 Reset asserted mid-transaction SHALL abandon the transaction; no stale response SHALL be routed after reset release.

Configuration
REQ-024 With macro PTW_ARB_FIXED_PRIO_EN defined, selection SHALL be fixed priority (highest index wins, DTLB over ITLB) and rr_ptr_q SHALL not exist.
REQ-025 Without PTW_ARB_FIXED_PRIO_EN, round-robin per REQ-011 SHALL apply.

Structure
REQ-026 The ptw_arb_state_t enum and constant PTW_ARB_N_REQ = 2 SHALL reside in mmu_pkg; tlb_ptw_comm_t and ptw_tlb_comm_t SHALL be reused unchanged.
REQ-027 Winner selection SHALL be a sub-module ptw_arb_sel (inputs: valid vector, rr_ptr; outputs: winner index, any_valid).

Verification
REQ-028 Single requester: ITLB req.valid with vpn 0x12345, ptw_ready on cycle 2 -> PTW sees vpn 0x12345 at cycle 1; only ITLB gets resp.valid; state returns to IDLE.
REQ-029 Contention: both valid at reset, rr_ptr = 0 -> ITLB granted first; after its response, DTLB granted; rr_ptr ends at 0.
REQ-030 Cancel: DTLB granted, DTLB drops valid before ptw_ready -> IDLE next cycle; no PTW request observed afterwards.
REQ-031 Invalidate in WAIT: invalidate_tlb pulses, resp.valid arrives 5 cycles later -> FLUSH_WAIT, response routed to grantee, then IDLE.
REQ-032 Isolation: while ITLB is in WAIT, DTLB asserts valid for 20 cycles -> DTLB sees ptw_ready = 0 and resp.valid = 0 throughout, then is granted in the next IDLE.
REQ-033 With PTW_ARB_FIXED_PRIO_EN: both valid repeatedly -> DTLB wins every arbitration.
